// File: rtl/bp_me_cce_bcast_sequencer_pkg.sv
// Shared types and the coherence-NoC geometry used by the broadcast sequencer.
package bp_me_cce_bcast_sequencer_pkg;

    // Broadcast sequencing states
    typedef enum logic [1:0] {
        e_ready,
        e_send,
        e_wait,
        e_done
    } bp_me_bcast_state_e;

    // Core-complex geometry (2x2 complex, no SAC columns, one I/O row above)
    localparam int cc_x_dim_p  = 2;
    localparam int cc_y_dim_p  = 2;
    localparam int sac_x_dim_p = 0;
    localparam int ic_y_dim_p  = 1;

    localparam int num_cce_p      = cc_x_dim_p * cc_y_dim_p;
    localparam int cce_id_width_p = $clog2(num_cce_p);

    localparam int coh_noc_x_cord_width_p = 2;
    localparam int coh_noc_y_cord_width_p = 2;
    localparam int coh_noc_cord_width_p   = coh_noc_x_cord_width_p + coh_noc_y_cord_width_p;
    localparam int coh_noc_cid_width_p    = 1;

endpackage

// File: rtl/bp_me_cce_bcast_sequencer_id_to_cord.sv
// Maps a CCE id onto its coherence-NoC coordinate {y, x} and concentrator id.
module bp_me_cce_bcast_sequencer_id_to_cord
    import bp_me_cce_bcast_sequencer_pkg::*;
(
    input  logic [cce_id_width_p-1:0]       cce_id_i,
    output logic [coh_noc_cord_width_p-1:0] cord_o,
    output logic [coh_noc_cid_width_p-1:0]  cid_o
);

    localparam logic [cce_id_width_p-1:0]         cc_x_dim_l = cce_id_width_p'(cc_x_dim_p);
    localparam logic [coh_noc_x_cord_width_p-1:0] x_base_l   = coh_noc_x_cord_width_p'(sac_x_dim_p);
    localparam logic [coh_noc_y_cord_width_p-1:0] y_base_l   = coh_noc_y_cord_width_p'(ic_y_dim_p);

    logic [coh_noc_x_cord_width_p-1:0] x_cord;
    logic [coh_noc_y_cord_width_p-1:0] y_cord;

    // CCEs are laid out row-major across the complex, offset past SAC columns and the I/O row
    always_comb begin
        x_cord = x_base_l + coh_noc_x_cord_width_p'(cce_id_i % cc_x_dim_l);
        y_cord = y_base_l + coh_noc_y_cord_width_p'(cce_id_i / cc_x_dim_l);
        cord_o = {y_cord, x_cord};
        cid_o  = '0;
    end

endmodule

// File: rtl/bp_me_cce_bcast_sequencer.sv
// Fans one broadcast command out to every CCE in a mask, lowest id first,
// then waits for one ack per packet before raising done.
module bp_me_cce_bcast_sequencer
    import bp_me_cce_bcast_sequencer_pkg::*;
#(
    parameter int payload_width_p = 64
)(
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            cmd_v_i,
    output logic                            cmd_ready_and_o,
    input  logic [num_cce_p-1:0]            cmd_mask_i,
    input  logic [payload_width_p-1:0]      cmd_payload_i,
    output logic                            pkt_v_o,
    input  logic                            pkt_ready_and_i,
    output logic [cce_id_width_p-1:0]       pkt_cce_id_o,
    output logic [coh_noc_cord_width_p-1:0] pkt_cord_o,
    output logic [coh_noc_cid_width_p-1:0]  pkt_cid_o,
    output logic [payload_width_p-1:0]      pkt_payload_o,
    input  logic                            ack_v_i,
    output logic                            done_v_o,
    input  logic                            done_yumi_i,
    output logic                            err_o
);

    localparam int cnt_w = $clog2(num_cce_p + 1);

    bp_me_bcast_state_e             state_r, state_n;
    logic [num_cce_p-1:0]           mask_r, mask_n, mask_clr;
    logic [payload_width_p-1:0]     payload_r;
    logic [cnt_w-1:0]               count_r, count_n;
    logic                           err_r, err_n;
    logic [cce_id_width_p-1:0]      target_id;
    logic                           cmd_hs, pkt_hs;

    // Lowest set bit wins; an empty mask encodes to id 0
    function automatic logic [cce_id_width_p-1:0] lowest_set(input logic [num_cce_p-1:0] m);
        lowest_set = '0;
        for (int i = num_cce_p - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = cce_id_width_p'(i);
        end
    endfunction

    assign target_id = lowest_set(mask_r);
    assign mask_clr  = mask_r & ~(num_cce_p'(1) << target_id);
    assign cmd_hs    = (state_r == e_ready) && cmd_v_i;
    assign pkt_hs    = (state_r == e_send) && pkt_ready_and_i;

    bp_me_cce_bcast_sequencer_id_to_cord id_to_cord (
        .cce_id_i (target_id),
        .cord_o   (pkt_cord_o),
        .cid_o    (pkt_cid_o)
    );

    assign cmd_ready_and_o = (state_r == e_ready);
    assign pkt_v_o         = (state_r == e_send);
    assign done_v_o        = (state_r == e_done);
    assign pkt_cce_id_o    = target_id;
    assign pkt_payload_o   = payload_r;
    assign err_o           = err_r;

    // Next state, target mask, outstanding-ack count and sticky error
    always_comb begin
        state_n = state_r;
        mask_n  = mask_r;
        count_n = count_r;
        err_n   = err_r;

        // A send in the same cycle covers an ack arriving against a zero count
        if (pkt_hs) begin
            count_n = count_n + cnt_w'(1);
            mask_n  = mask_clr;
        end
        if (ack_v_i) begin
            if (count_n == '0) err_n   = 1'b1;
            else               count_n = count_n - cnt_w'(1);
        end
        if (cmd_hs) begin
            mask_n  = cmd_mask_i;
            count_n = '0;
        end

        case (state_r)
            e_ready: if (cmd_v_i) state_n = (cmd_mask_i != '0) ? e_send : e_done;
            e_send:  if (pkt_hs && (mask_clr == '0)) state_n = (count_n == '0) ? e_done : e_wait;
            e_wait:  if (count_n == '0) state_n = e_done;
            e_done:  if (done_yumi_i) state_n = e_ready;
            default: state_n = e_ready;
        endcase
    end

    // State and datapath registers; reset abandons any broadcast in flight
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= e_ready;
            mask_r    <= '0;
            payload_r <= '0;
            count_r   <= '0;
            err_r     <= 1'b0;
        end else begin
            state_r <= state_n;
            mask_r  <= mask_n;
            count_r <= count_n;
            err_r   <= err_n;
            if (cmd_hs) payload_r <= cmd_payload_i;
        end
    end

endmodule

// File: tb/tb_bp_me_cce_bcast_sequencer.sv
// Directed and randomized bench for the CCE broadcast sequencer, checked
// against a transaction-level model built from queues of pending targets.
module tb_bp_me_cce_bcast_sequencer;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        cmd_v_i;
    logic        cmd_ready_and_o;
    logic [3:0]  cmd_mask_i;
    logic [63:0] cmd_payload_i;
    logic        pkt_v_o;
    logic        pkt_ready_and_i;
    logic [1:0]  pkt_cce_id_o;
    logic [3:0]  pkt_cord_o;
    logic [0:0]  pkt_cid_o;
    logic [63:0] pkt_payload_o;
    logic        ack_v_i;
    logic        done_v_o;
    logic        done_yumi_i;
    logic        err_o;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: targets still to send, acks owed, and completion flags
    int          pend_q[$];
    int          outstanding = 0;
    bit          busy = 0;
    bit          done_p = 0;
    bit          err_m = 0;
    logic [63:0] pay_m = '0;

    always #5 clk = ~clk;

    bp_me_cce_bcast_sequencer #(.payload_width_p(64)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .cmd_v_i         (cmd_v_i),
        .cmd_ready_and_o (cmd_ready_and_o),
        .cmd_mask_i      (cmd_mask_i),
        .cmd_payload_i   (cmd_payload_i),
        .pkt_v_o         (pkt_v_o),
        .pkt_ready_and_i (pkt_ready_and_i),
        .pkt_cce_id_o    (pkt_cce_id_o),
        .pkt_cord_o      (pkt_cord_o),
        .pkt_cid_o       (pkt_cid_o),
        .pkt_payload_o   (pkt_payload_o),
        .ack_v_i         (ack_v_i),
        .done_v_o        (done_v_o),
        .done_yumi_i     (done_yumi_i),
        .err_o           (err_o)
    );

    // 2x2 complex, CCEs row-major, one I/O row above: x = id mod 2, y = 1 + id div 2
    function automatic logic [3:0] cord_of(input int id);
        int x, y;
        logic [1:0] xs, ys;
        x  = id % 2;
        y  = 1 + id / 2;
        xs = x[1:0];
        ys = y[1:0];
        return {ys, xs};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit s_busy, s_done, send;
        s_busy = busy;
        s_done = done_p;
        if (reset_i) begin
            pend_q.delete();
            outstanding = 0;
            busy = 0; done_p = 0; err_m = 0; pay_m = '0;
            return;
        end
        send = busy && !done_p && (pend_q.size() > 0) && pkt_ready_and_i;
        if (send) begin
            void'(pend_q.pop_front());
            outstanding++;
        end
        if (ack_v_i) begin
            if (outstanding == 0) err_m = 1;
            else outstanding--;
        end
        if (!s_busy && cmd_v_i) begin
            pend_q.delete();
            for (int i = 0; i < 4; i++) if (cmd_mask_i[i]) pend_q.push_back(i);
            outstanding = 0;
            busy = 1;
            pay_m = cmd_payload_i;
            done_p = (cmd_mask_i == 4'b0000);
        end else if (s_busy && !s_done && pend_q.size() == 0 && outstanding == 0) begin
            done_p = 1;
        end else if (s_done && done_yumi_i) begin
            busy = 0;
            done_p = 0;
        end
    endtask

    task automatic check_all();
        bit exp_pkt;
        exp_pkt = busy && !done_p && (pend_q.size() > 0);
        chk("cmd_ready", 64'(cmd_ready_and_o), 64'(!busy));
        chk("pkt_v", 64'(pkt_v_o), 64'(exp_pkt));
        chk("done_v", 64'(done_v_o), 64'(done_p));
        chk("err", 64'(err_o), 64'(err_m));
        if (exp_pkt) begin
            chk("pkt_id", 64'(pkt_cce_id_o), 64'(pend_q[0]));
            chk("pkt_cord", 64'(pkt_cord_o), 64'(cord_of(pend_q[0])));
            chk("pkt_cid", 64'(pkt_cid_o), 64'(0));
            chk("pkt_payload", pkt_payload_o, pay_m);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit cv, input logic [3:0] m, input logic [63:0] p,
                         input bit rdy, input bit ack, input bit yumi, input bit rst);
        cmd_v_i = cv; cmd_mask_i = m; cmd_payload_i = p;
        pkt_ready_and_i = rdy; ack_v_i = ack; done_yumi_i = yumi; reset_i = rst;
        tick();
    endtask

    initial begin
        cmd_v_i = 0; cmd_mask_i = '0; cmd_payload_i = '0; pkt_ready_and_i = 0;
        ack_v_i = 0; done_yumi_i = 0; reset_i = 1;

        // Reset state
        drive(0, 4'h0, 64'h0, 0, 0, 0, 1);
        drive(0, 4'h0, 64'h0, 0, 0, 0, 1);
        chk("rst_id", 64'(pkt_cce_id_o), 64'(0));
        chk("rst_payload", pkt_payload_o, 64'h0);

        // 1: mask 1010, ready high, ack one cycle after each send
        drive(1, 4'b1010, 64'hA5A5_0001_DEAD_BEEF, 1, 0, 0, 0);
        chk("t1_id1", 64'(pkt_cce_id_o), 64'(1));
        chk("t1_cord1", 64'(pkt_cord_o), 64'(4'b0101));
        drive(0, 4'h0, 64'h0, 1, 0, 0, 0);
        chk("t1_id3", 64'(pkt_cce_id_o), 64'(3));
        chk("t1_cord3", 64'(pkt_cord_o), 64'(4'b1001));
        drive(0, 4'h0, 64'h0, 1, 1, 0, 0);
        chk("t1_wait", 64'(done_v_o), 64'(0));
        drive(0, 4'h0, 64'h0, 1, 1, 0, 0);
        chk("t1_done", 64'(done_v_o), 64'(1));
        drive(0, 4'h0, 64'h0, 0, 0, 1, 0);

        // 2: empty mask goes straight to done
        drive(1, 4'b0000, 64'h2222, 1, 0, 0, 0);
        chk("t2_nopkt", 64'(pkt_v_o), 64'(0));
        chk("t2_done", 64'(done_v_o), 64'(1));
        drive(0, 4'h0, 64'h0, 0, 0, 1, 0);

        // 3: mask 1111 with ready low for 3 cycles on id2
        drive(1, 4'b1111, 64'h3333_4444_5555_6666, 1, 0, 0, 0);
        drive(0, 4'h0, 64'h0, 1, 0, 0, 0);
        drive(0, 4'h0, 64'h0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 4'h0, 64'h0, 0, 0, 0, 0);
            chk("t3_hold_id", 64'(pkt_cce_id_o), 64'(2));
            chk("t3_hold_pay", pkt_payload_o, 64'h3333_4444_5555_6666);
        end
        drive(0, 4'h0, 64'h0, 1, 0, 0, 0);
        drive(0, 4'h0, 64'h0, 1, 1, 0, 0);
        drive(0, 4'h0, 64'h0, 0, 1, 0, 0);
        drive(0, 4'h0, 64'h0, 0, 1, 0, 0);
        drive(0, 4'h0, 64'h0, 0, 1, 0, 0);
        chk("t3_done", 64'(done_v_o), 64'(1));
        drive(0, 4'h0, 64'h0, 0, 0, 1, 0);

        // 4: single target, ack in the same cycle as the send
        drive(1, 4'b0001, 64'h4444, 0, 0, 0, 0);
        drive(0, 4'h0, 64'h0, 1, 1, 0, 0);
        chk("t4_done", 64'(done_v_o), 64'(1));
        chk("t4_err", 64'(err_o), 64'(0));
        drive(0, 4'h0, 64'h0, 0, 0, 1, 0);

        // 5: stray ack while idle, then a normal broadcast
        drive(0, 4'h0, 64'h0, 0, 1, 0, 0);
        chk("t5_err", 64'(err_o), 64'(1));
        drive(1, 4'b0100, 64'h5555, 1, 0, 0, 0);
        drive(0, 4'h0, 64'h0, 1, 0, 0, 0);
        drive(0, 4'h0, 64'h0, 0, 1, 0, 0);
        chk("t5_done", 64'(done_v_o), 64'(1));
        drive(0, 4'h0, 64'h0, 0, 0, 1, 0);

        // 6: reset while two acks are outstanding
        drive(1, 4'b1010, 64'h6666, 1, 0, 0, 0);
        drive(0, 4'h0, 64'h0, 1, 0, 0, 0);
        drive(0, 4'h0, 64'h0, 1, 0, 0, 0);
        drive(0, 4'h0, 64'h0, 0, 0, 0, 1);
        chk("t6_ready", 64'(cmd_ready_and_o), 64'(1));
        chk("t6_done", 64'(done_v_o), 64'(0));
        chk("t6_err", 64'(err_o), 64'(0));

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 2) != 0,
                  4'($urandom_range(0, 15)),
                  {$urandom, $urandom},
                  $urandom_range(0, 3) != 0,
                  (outstanding > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 59) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
